// File: rtl/spi_tx.sv
// spi_tx: SPI mode-0 master transmitter. Takes bytes over a valid/ready handshake
// and shifts each one out MSB-first on Sclk/Mosi, framed by an active-low CSel.
// Latency: CSel falls on the accept edge; a lone byte takes 19*HALF_PERIOD Clk cycles
// from accept back to IDLE.
// Backpressure: DataReady is high only in IDLE. With burst mode it is also high on
// the last HOLD cycle. DataValid without DataReady is ignored.
//
// Optional build macro: SPI_TX_BURST_EN. When it is defined, a byte offered on the
// last HOLD cycle is chained into the same CSel frame, and SETUP and GAP are skipped.
//
// Ports:
//   Clk        system clock, rising edge
//   RstN       asynchronous active-low reset
//   DataIn     byte to send, sampled on the accept cycle only
//   DataValid  DataIn holds a byte to send
//   DataReady  block can accept a byte this cycle
//   Busy       state is not IDLE
//   Done       one-cycle pulse on the final cycle of a byte (last HOLD cycle)
//   Sclk       SPI clock, idles low
//   Mosi       serial data, changes only while Sclk is low
//   CSel       chip select, active low

module spi_tx #(
    parameter int HALF_PERIOD = 10,
    parameter int CNT_W       = $clog2(HALF_PERIOD + 1)
) (
    input  logic       Clk,
    input  logic       RstN,
    input  logic [7:0] DataIn,
    input  logic       DataValid,
    output logic       DataReady,
    output logic       Busy,
    output logic       Done,
    output logic       Sclk,
    output logic       Mosi,
    output logic       CSel
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_LOW   = 3'd2;
    localparam logic [2:0] ST_HIGH  = 3'd3;
    localparam logic [2:0] ST_HOLD  = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;

    localparam logic [CNT_W-1:0] PH_LAST = CNT_W'(HALF_PERIOD - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic [2:0]       bit_q,   bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             sclk_q,  sclk_d;
    logic             mosi_q,  mosi_d;
    logic             csel_q,  csel_d;
    logic             done_q,  done_d;

    logic             phase_tc;
    logic             accept;

    assign phase_tc = (phase_q == PH_LAST);

    // DataReady and Busy are decoded straight from the state register.
`ifdef SPI_TX_BURST_EN
    assign DataReady = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && phase_tc);
`else
    assign DataReady = (state_q == ST_IDLE);
`endif
    assign Busy   = (state_q != ST_IDLE);
    assign accept = DataValid && DataReady;

    // Next-state logic. Every non-IDLE state lasts exactly HALF_PERIOD cycles.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        shift_d = shift_q;

        if (state_q == ST_IDLE) begin
            phase_d = '0;
            if (accept) begin
                state_d = ST_SETUP;
                shift_d = DataIn;
                bit_d   = 3'd7;
            end
        end else if (!phase_tc) begin
            phase_d = phase_q + CNT_W'(1);
        end else begin
            phase_d = '0;
            case (state_q)
                ST_SETUP: state_d = ST_LOW;
                ST_LOW:   state_d = ST_HIGH;
                ST_HIGH: begin
                    if (bit_q != 3'd0) begin
                        // The shift happens as LOW begins, so Mosi only moves
                        // while Sclk is low.
                        bit_d   = bit_q - 3'd1;
                        shift_d = {shift_q[6:0], 1'b0};
                        state_d = ST_LOW;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
`ifdef SPI_TX_BURST_EN
                    if (accept) begin
                        shift_d = DataIn;
                        bit_d   = 3'd7;
                        state_d = ST_LOW;
                    end else begin
                        state_d = ST_GAP;
                    end
`else
                    state_d = ST_GAP;
`endif
                end
                ST_GAP:   state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // The pins are registered from the next-state values. This keeps them
    // glitch-free and still lines them up exactly with the state they belong to.
    always_comb begin
        sclk_d = (state_d == ST_HIGH);
        csel_d = !((state_d == ST_SETUP) || (state_d == ST_LOW) ||
                   (state_d == ST_HIGH)  || (state_d == ST_HOLD));
        mosi_d = ((state_d == ST_LOW) || (state_d == ST_HIGH) || (state_d == ST_HOLD))
                 ? shift_d[7] : 1'b0;
        // Done is high during the last HOLD cycle.
        done_d = (state_d == ST_HOLD) && (phase_d == PH_LAST);
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            csel_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            sclk_q  <= sclk_d;
            mosi_q  <= mosi_d;
            csel_q  <= csel_d;
            done_q  <= done_d;
        end
    end

    assign Sclk = sclk_q;
    assign Mosi = mosi_q;
    assign CSel = csel_q;
    assign Done = done_q;

endmodule

// File: tb/tb_spi_tx.sv
// tb_spi_tx: randomized scoreboard bench for spi_tx. Two instances are used, one
// with HALF_PERIOD=10 and one with HALF_PERIOD=1.
// Latency: not applicable.
// Backpressure: the stimulus waits for DataReady; the monitor decodes the SPI pins.

module tb_spi_tx;

    localparam int HP0 = 10;
    localparam int HP1 = 1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] din0  = 8'h00;
    logic [7:0] din1  = 8'h00;
    logic       dv0   = 1'b0;
    logic       dv1   = 1'b0;
    logic [1:0] rdy, busy, done, sclk, mosi, csel;

    always #5 clk = ~clk;

    spi_tx #(.HALF_PERIOD(HP0)) u_dut0 (
        .Clk(clk), .RstN(rst_n), .DataIn(din0), .DataValid(dv0),
        .DataReady(rdy[0]), .Busy(busy[0]), .Done(done[0]),
        .Sclk(sclk[0]), .Mosi(mosi[0]), .CSel(csel[0])
    );

    spi_tx #(.HALF_PERIOD(HP1)) u_dut1 (
        .Clk(clk), .RstN(rst_n), .DataIn(din1), .DataValid(dv1),
        .DataReady(rdy[1]), .Busy(busy[1]), .Done(done[1]),
        .Sclk(sclk[1]), .Mosi(mosi[1]), .CSel(csel[1])
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q0[$];
    logic [7:0] exp_q1[$];

    int accepts[2], bytes_rx[2], dones[2], rises[2], windows[2];
    int bitcnt[2], stable[2], low_len[2], high_len[2], last_win[2];
    int busy_len[2], last_busy[2], last_rise[2];
    int cyc = 0;
    bit [7:0] shreg[2];
    bit prev_sclk[2], prev_csel[2], prev_mosi[2], prev_done[2], prev_busy[2];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_ge(input string name, input int act, input int lim);
        checks++;
        if (act < lim) begin
            errors++;
            $display("FAIL %s: got %0d, expected at least %0d", name, act, lim);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Handshake tracker. A byte offered while DataReady is high is taken at the next
    // rising edge, so its expected serial image goes into the scoreboard now.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dv0 && rdy[0]) begin exp_q0.push_back(din0); accepts[0]++; end
            if (dv1 && rdy[1]) begin exp_q1.push_back(din1); accepts[1]++; end
        end
    end

    // Receiver-side monitor. Mosi is sampled on each Sclk rise, 8 rises make a byte,
    // and each byte is compared with the head of the scoreboard.
    task automatic mon_step(input int d);
        int hp;
        logic [7:0] exp_b;
        hp = (d == 0) ? HP0 : HP1;
        if (mosi[d] == prev_mosi[d]) stable[d]++; else stable[d] = 1;
        if (!rst_n) begin
            bitcnt[d]   = 0;
            high_len[d] = 1000;
            low_len[d]  = 0;
            busy_len[d] = 0;
        end else begin
            if (done[d]) begin
                dones[d]++;
                chk("done_width", int'(prev_done[d]), 0);
                chk("done_vs_bytes", dones[d], bytes_rx[d]);
            end
            if (prev_sclk[d] && sclk[d])
                chk("mosi_stable_high", int'(mosi[d]), int'(prev_mosi[d]));
            if (sclk[d] && !prev_sclk[d]) begin
                chk("sclk_needs_cs", int'(csel[d]), 0);
                chk_ge("mosi_setup", stable[d], hp + 1);
                if (bitcnt[d] != 0) chk("sclk_period", cyc - last_rise[d], 2 * hp);
                last_rise[d] = cyc;
                rises[d]++;
                shreg[d] = {shreg[d][6:0], mosi[d]};
                bitcnt[d]++;
                if (bitcnt[d] == 8) begin
                    bitcnt[d] = 0;
                    bytes_rx[d]++;
                    if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL byte_unexpected: dut%0d got %02h, expected none", d, shreg[d]);
                    end else begin
                        if (d == 0) exp_b = exp_q0.pop_front();
                        else        exp_b = exp_q1.pop_front();
                        chk("byte", int'(shreg[d]), int'(exp_b));
                    end
                end
            end
            if (!csel[d] && prev_csel[d]) begin
                windows[d]++;
                chk_ge("cs_gap", high_len[d], hp + 1);
                low_len[d] = 0;
            end
            if (csel[d] && !prev_csel[d]) begin
                last_win[d] = low_len[d];
                chk("cs_rise_whole_bytes", bitcnt[d], 0);
                high_len[d] = 0;
            end
            if (!csel[d]) low_len[d]++; else high_len[d]++;
            if (busy[d]) busy_len[d]++;
            else if (prev_busy[d]) begin
                last_busy[d] = busy_len[d];
                busy_len[d]  = 0;
            end
        end
        prev_sclk[d] = sclk[d];
        prev_csel[d] = csel[d];
        prev_mosi[d] = mosi[d];
        prev_done[d] = done[d];
        prev_busy[d] = busy[d];
    endtask

    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) mon_step(d);
    end

    task automatic send(input int d, input logic [7:0] b);
        int n;
        @(posedge clk); #1;
        if (d == 0) begin din0 = b; dv0 = 1'b1; end
        else        begin din1 = b; dv1 = 1'b1; end
        n = 0;
        while (n < 1000) begin
            @(negedge clk);
            if (rdy[d]) break;
            n++;
        end
        if (n >= 1000) fail_now("accept_timeout");
        @(posedge clk); #1;
        if (d == 0) dv0 = 1'b0; else dv1 = 1'b0;
    endtask

    task automatic wait_idle(input int d);
        int n;
        n = 0;
        while (n < 3000) begin
            @(negedge clk);
            if (!busy[d]) break;
            n++;
        end
        if (n >= 3000) fail_now("idle_timeout");
        @(negedge clk); #1;
    endtask

    task automatic check_idle_pins(input int d, input string tag);
        chk({tag, "_csel"}, int'(csel[d]), 1);
        chk({tag, "_sclk"}, int'(sclk[d]), 0);
        chk({tag, "_mosi"}, int'(mosi[d]), 0);
        chk({tag, "_done"}, int'(done[d]), 0);
        chk({tag, "_busy"}, int'(busy[d]), 0);
        chk({tag, "_ready"}, int'(rdy[d]), 1);
    endtask

    initial begin
        #200_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, d0, w0, a0, b0, n, last;
        logic [7:0] b;

        // Reset
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_idle_pins(0, "in_reset0");
        @(negedge clk); #2 rst_n = 1'b1;
        @(negedge clk); #1;
        check_idle_pins(0, "after_reset0");
        check_idle_pins(1, "after_reset1");

        // Single 0x41 at HALF_PERIOD=10
        r0 = rises[0]; d0 = dones[0]; w0 = windows[0];
        send(0, 8'h41);
        chk("accept_to_cs_low", int'(csel[0]), 0);
        chk("accept_to_busy", int'(busy[0]), 1);
        wait_idle(0);
        chk("t1_cs_low_len", last_win[0], 18 * HP0);
        chk("t1_busy_len", last_busy[0], 19 * HP0);
        chk("t1_rises", rises[0] - r0, 8);
        chk("t1_dones", dones[0] - d0, 1);
        chk("t1_windows", windows[0] - w0, 1);

        // Loopback sequence, then random bytes
        d0 = dones[0]; b0 = bytes_rx[0];
        send(0, 8'h41);
        for (int i = 0; i < 3; i++) send(0, 8'hC0);
        for (int i = 0; i < 12; i++) begin
            b = 8'($urandom);
            if (i == 3) b = 8'h00;
            if (i == 7) b = 8'hFF;
            send(0, b);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        wait_idle(0);
        chk("t2_bytes", bytes_rx[0] - b0, 16);
        chk("t2_dones", dones[0] - d0, 16);
        chk("t2_queue_empty", exp_q0.size(), 0);

        // DataValid held high for 4 bytes
        r0 = rises[0]; d0 = dones[0]; w0 = windows[0]; a0 = accepts[0];
        @(posedge clk); #1;
        din0 = 8'($urandom); dv0 = 1'b1;
        last = accepts[0]; n = 0;
        while (accepts[0] - a0 < 4 && n < 5000) begin
            @(posedge clk); #1;
            n++;
            if (accepts[0] != last) begin last = accepts[0]; din0 = 8'($urandom); end
            if (accepts[0] - a0 >= 4) dv0 = 1'b0;
        end
        dv0 = 1'b0;
        if (n >= 5000) fail_now("t3_accept_timeout");
        wait_idle(0);
        chk("t3_dones", dones[0] - d0, 4);
        chk("t3_rises", rises[0] - r0, 32);
`ifdef SPI_TX_BURST_EN
        chk("t3_windows", windows[0] - w0, 1);
        chk("t3_window_len", last_win[0], 69 * HP0);
`else
        chk("t3_windows", windows[0] - w0, 4);
        chk("t3_window_len", last_win[0], 18 * HP0);
`endif
        chk("t3_queue_empty", exp_q0.size(), 0);

        // Reset during bit 3 of 0xA5, then 0x3C
        r0 = rises[0];
        send(0, 8'hA5);
        n = 0;
        while (rises[0] - r0 < 5 && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) fail_now("t5_rise_timeout");
        #2 rst_n = 1'b0;
        #1;
        check_idle_pins(0, "t5_mid_reset");
        exp_q0.delete();
        exp_q1.delete();
        d0 = dones[0];
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("t5_no_done", dones[0] - d0, 0);
        b0 = bytes_rx[0];
        send(0, 8'h3C);
        wait_idle(0);
        chk("t5_after_bytes", bytes_rx[0] - b0, 1);
        chk("t5_after_dones", dones[0] - d0, 1);
        chk("t5_queue_empty", exp_q0.size(), 0);

        // HALF_PERIOD=1: 0xFF then 0x00, with DataValid pulses while busy
        a0 = accepts[1]; b0 = bytes_rx[1]; d0 = dones[1]; r0 = rises[1];
        for (int k = 0; k < 2; k++) begin
            send(1, (k == 0) ? 8'hFF : 8'h00);
            n = 0;
            while (n < 100) begin
                @(negedge clk);
                if (!busy[1]) break;
                if (!rdy[1] && n[0]) begin
                    din1 = 8'($urandom);
                    dv1  = 1'b1;
                    @(posedge clk); #1;
                    dv1  = 1'b0;
                end
                n++;
            end
            if (n >= 100) fail_now("t6_idle_timeout");
        end
        wait_idle(1);
        chk("t6_accepts", accepts[1] - a0, 2);
        chk("t6_bytes", bytes_rx[1] - b0, 2);
        chk("t6_dones", dones[1] - d0, 2);
        chk("t6_rises", rises[1] - r0, 16);
        chk("t6_cs_low_len", last_win[1], 18 * HP1);
        chk("t6_busy_len", last_busy[1], 19 * HP1);
        chk("t6_queue_empty", exp_q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
